uart_rx_ctrl: RTL and testbench

//  UART RX frame controller. Sits directly downstream of the start bit detector.
//  - Consumes its one-cycle falling-edge strobe and the synchronised serial line.
//  - Times bit periods, samples mid-bit, assembles an LSB-first data byte.
//  - Checks the stop bit; presents the byte with ready/overrun/framing status.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/rx_bit_timer.sv | 35 +++
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned CLKS_PER_BIT_DEF = 10;
    localparam int unsigned DATA_BITS_DEF    = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: counts while enabled and emits a one-cycle tick at rollover_val.
// The count reloads to 0 on the tick.
module rx_bit_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;

    assign tick = enable && (count_q == rollover_val);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: centres on the start bit, samples mid-bit,
// assembles an LSB-first byte and reports ready/overrun/framing status.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_bit,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned TMR_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W    = $clog2(DATA_BITS);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;

    logic             tick;
    logic             tmr_clear;
    logic [TMR_W-1:0] tmr_rollover;

    // Every state exit except IDLE->START_CHK happens on a tick, which already
    // reloads the timer, so holding it clear in IDLE restarts it on each entry.
    assign tmr_clear    = (state_q == IDLE);
    assign tmr_rollover = (state_q == START_CHK) ? TMR_W'(HALF_BIT - 1)
                                                 : TMR_W'(CLKS_PER_BIT - 1);

    rx_bit_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (tmr_clear),
        .enable      (!tmr_clear),
        .rollover_val(tmr_rollover),
        .tick        (tick)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        framing_d    = framing_q;

        // A read is applied first so that a simultaneous good-stop load overrides it.
        if (data_read && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_bit) begin
                    state_d = START_CHK;
                end
            end
            START_CHK: begin
                if (tick) begin
                    if (serial_in) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = {serial_in, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (serial_in) begin
                        rx_data_d    = shreg_q;
                        data_ready_d = 1'b1;
                        framing_d    = 1'b0;
                        if (data_ready_q && !data_read) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        framing_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            framing_q    <= framing_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLKS_PER_BIT=10, DATA_BITS=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start_bit;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl #(
        .CLKS_PER_BIT(10),
        .DATA_BITS   (8)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start_bit    (start_bit),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives frame cycles t0+first .. t0+last. On return the falling edge after
    // edge t0+last has passed, so outputs reflect cycle t0+last+1.
    task automatic drive_cycles(input logic [7:0] d, input logic stop, input bit read_at_stop,
                                input int first, input int last, input bit chk_busy);
        logic exp_busy;
        for (int c = first; c <= last; c++) begin
            if (chk_busy && (c == 0 || c == 1 || c == 95)) begin
                exp_busy = (c != 0);
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy_c%0d: got %b expected %b", c, busy, exp_busy);
                end
            end
            start_bit = (c == 0);
            if (c < 10)      serial_in = 1'b0;
            else if (c < 90) serial_in = d[(c - 10) / 10];
            else             serial_in = stop;
            data_read = read_at_stop && (c == 95);
            @(negedge clk);
        end
        start_bit = 1'b0;
        data_read = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit read_at_stop);
        drive_cycles(d, stop, read_at_stop, 0, 95, 1'b1);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [7:0] e_data, input logic e_rdy,
                              input logic e_ov, input logic e_fe, input logic e_busy);
        checks++;
        if ({rx_data, data_ready, overrun_error, framing_error, busy} !==
            {e_data, e_rdy, e_ov, e_fe, e_busy}) begin
            errors++;
            $display("FAIL %s: got data=%h rdy=%b ov=%b fe=%b busy=%b expected data=%h rdy=%b ov=%b fe=%b busy=%b",
                     name, rx_data, data_ready, overrun_error, framing_error, busy,
                     e_data, e_rdy, e_ov, e_fe, e_busy);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start_bit = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_data, data_ready, overrun_error, framing_error, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset: got data=%h rdy=%b ov=%b fe=%b busy=%b expected all 0",
                     rx_data, data_ready, overrun_error, framing_error, busy);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b1, 1'b0);
        check_outs("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_read();
        check_outs("read_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_false_start();
        for (int c = 0; c <= 5; c++) begin
            start_bit = (c == 0);
            serial_in = (c < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        start_bit = 1'b0;
        serial_in = 1'b1;
        // Cycle t0+6: state has already returned to IDLE.
        check_outs("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        check_outs("framing_bad", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_outs("framing_clear", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_read();
    endtask

    task automatic test_back_to_back_overrun();
        send_frame(8'h11, 1'b1, 1'b0);
        check_outs("b2b_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_outs("overrun_22", 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_read();
        check_outs("overrun_read", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_read();
        check_outs("read_idle", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_read_at_stop();
        send_frame(8'h66, 1'b1, 1'b0);
        check_outs("pre_66", 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        check_outs("read_at_stop", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        drive_cycles(8'h5A, 1'b1, 1'b0, 0, 40, 1'b0);
        check_outs("pre_rst_busy", 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        n_rst = 1'b0;
        #1;
        check_outs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        start_bit = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_outs("frame_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_false_start();
        test_framing();
        test_back_to_back_overrun();
        test_read_at_stop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
